// File: rtl/phase_vec_sram_reader_pkg.sv
// phase_vec_sram_reader_pkg
// Shared definitions for the phase/frequency vector SRAM readout engine:
//   - state_t   : readout FSM encoding (2 bits), also exported on the debug port
//   - BUF_DEPTH : entries in the output skid buffer
//   - OCC_W     : width of the buffer occupancy count (holds 0..BUF_DEPTH)
package phase_vec_sram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = 2;

endpackage

// File: rtl/phase_vec_sram_reader_rd_buf.sv
// phase_vec_rd_buf
// Two-entry synchronous FIFO that holds SRAM read data until the stream
// consumer takes it. The caller guarantees no push when full and no pop
// when empty.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears storage too)
//   push, din  : write one word at the end of the cycle
//   pop        : discard the head word at the end of the cycle
//   dout       : head word (stable until popped)
//   occ        : number of stored words, 0..BUF_DEPTH
module phase_vec_rd_buf
  import phase_vec_sram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [OCC_W-1:0]      occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  // One-bit pointers: the buffer is exactly two entries deep.
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: ;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/phase_vec_sram_reader.sv
// phase_vec_sram_reader
// Reads len consecutive SRAM words starting at base_adr (addresses wrap
// modulo DEPTH), hides the one-cycle SRAM read latency, and presents the
// words on a valid/ready stream without loss under back-pressure.
//
// Stream handshake: a word transfers in every cycle where dout_valid and
// dout_ready are both high; while dout_valid is high and dout_ready is low,
// dout and dout_valid hold their values. dout_valid never depends on
// dout_ready.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start, base_adr,len: request (accepted only when idle); len clamped to DEPTH
//   ren, radr, rdata   : SRAM read port; rdata valid the cycle after ren
//   dout, dout_valid,
//   dout_ready         : output stream
//   busy, done         : busy while transferring; done pulses once at the end
//   checksum           : wrap-around sum of accepted words
//                        (only when PHASE_VEC_READER_CHECKSUM_EN is defined)
//   dbg_state          : current FSM state
module phase_vec_sram_reader
  import phase_vec_sram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_adr,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] radr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done,
`ifdef PHASE_VEC_READER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  output state_t                dbg_state
);

  // Counts need one extra bit so that a count of DEPTH is representable.
  localparam int                    CNT_W    = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [CNT_W-1:0]        rem_q;
  logic                    inflight_q;
  logic [OCC_W-1:0]        occ;
  logic                    pop;
  logic                    accept;
  logic                    last_issue;
  logic [OCC_W:0]          pending;
  logic [CNT_W-1:0]        len_ext;
  logic [CNT_W-1:0]        len_clamped;
  logic [CNT_W-1:0]        base_ext;
  logic [ADDR_WIDTH-1:0]   base_wrapped;

  assign accept     = (state_q == ST_IDLE) && start;
  assign dout_valid = (occ != '0);
  assign pop        = dout_valid & dout_ready;

  // Words that will still occupy the buffer after this cycle if nothing new
  // is issued. Never underflows: pop implies occ >= 1.
  assign pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q}
                 - {{OCC_W{1'b0}}, pop};

  // Issue only when the word returning next cycle is sure to have a slot.
  assign ren        = (state_q == ST_READ) && (pending < (OCC_W + 1)'(BUF_DEPTH));
  assign last_issue = ren && (rem_q == CNT_W'(1));

  assign len_ext     = {1'b0, len};
  assign len_clamped = (len_ext > DEPTH_C) ? DEPTH_C : len_ext;

  // A single subtraction suffices because the address range is at most
  // twice DEPTH.
  assign base_ext     = {1'b0, base_adr};
  assign base_wrapped = (base_ext >= DEPTH_C) ? ADDR_WIDTH'(base_ext - DEPTH_C)
                                              : base_adr;

  assign radr      = adr_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        if (last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Leave as soon as the buffer will be empty after this cycle so that
        // done lands the cycle after the final word is accepted.
        if (!inflight_q && (occ == '0 || (occ == OCC_W'(1) && pop))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q      <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= ren;
      if (accept) begin
        adr_q <= base_wrapped;
        rem_q <= len_clamped;
      end else if (ren) begin
        adr_q <= (adr_q == LAST_ADR) ? '0 : adr_q + ADDR_WIDTH'(1);
        rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

  phase_vec_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_buf (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .din  (rdata),
    .pop  (pop),
    .dout (dout),
    .occ  (occ)
  );

`ifdef PHASE_VEC_READER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + dout;
    end
  end
`endif

endmodule

// File: doc/phase_vec_sram_reader.md
# phase_vec_sram_reader

Sequential readout engine for the phase/frequency vector SRAM's read-only port. On `start` it reads `len` consecutive words beginning at `base_adr`, modulo `DEPTH`. It absorbs the SRAM's one-cycle read latency and presents the words as a valid/ready stream. It is the consumer counterpart of the SRAM load path and feeds the debug readout or the kernel estimator without dropping data under back-pressure.

## Interface
- `DATA_WIDTH`, 16, SRAM word width.
- `ADDR_WIDTH`, 12, SRAM address width.
- `DEPTH`, 2048, number of SRAM words; addresses wrap modulo `DEPTH`.
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `base_adr`  in  ADDR_WIDTH  first word address, sampled with `start`.
- `len`  in  ADDR_WIDTH  word count, sampled with `start`; values above `DEPTH` are clamped to `DEPTH`.
- `ren`  out  1  SRAM read enable.
- `radr`  out  ADDR_WIDTH  SRAM read address.
- `rdata`  in  DATA_WIDTH  SRAM read data, valid the cycle after `ren`.
- `dout`  out  DATA_WIDTH  stream data.
- `dout_valid`  out  1  stream valid.
- `dout_ready`  in  1  stream ready.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `checksum`  out  DATA_WIDTH  present only with `PHASE_VEC_READER_CHECKSUM_EN`.

## Operation
- **States:** IDLE, READ, DRAIN, DONE.
- **IDLE → READ:** on `start` with `len` != 0. Latch `base_adr` into the address counter and the clamped `len` into the remaining-issue counter.
- **IDLE → DONE:** on `start` with `len` == 0. No SRAM access.
- **Read issue:**
  - In READ, assert `ren` when `occ + inflight - pop < 2`.
  - `occ` is the 2-entry output buffer occupancy, `inflight` is a read issued last cycle, and `pop` = `dout_valid & dout_ready`.
  - On each issue, `radr` increments; `DEPTH-1` wraps to 0.
- **READ → DRAIN:** on the last issue.
- **DRAIN → DONE:** when `occ` == 0, `inflight` == 0, and no pop is pending.
- **DONE:** `done` = 1 for one cycle, then return to IDLE.
- **Push:** when `inflight` = 1, capture `rdata` into the buffer. The buffer is FIFO-ordered and never overflows.
- **Stream:** `dout_valid` = (`occ` != 0); `dout` is the head entry. `dout` is held stable while `dout_valid` & !`dout_ready`.
- **`start` while not IDLE:** ignored.
- **Reset (including mid-operation):**
  - Next state IDLE; buffer, counters and `inflight` cleared.
  - `ren`, `radr`, `dout`, `dout_valid`, `busy`, `done` = 0; `checksum` = 0.
  - Any in-flight `rdata` is discarded.

## Timing
- `start` sampled high in cycle t (IDLE): `busy` = 1 and `ren` = 1 with `radr` = `base_adr` in cycle t+1.
- `rdata` arrives in cycle t+2 and is pushed at the end of t+2; `dout_valid` = 1 in cycle t+3.
- With `dout_ready` held high, throughput is 1 word/cycle. Last word of `len` = N is accepted in cycle t+N+2, and `done` pulses in cycle t+N+3.
- `busy` drops in the `done` cycle.
- With `len` = 0, `done` pulses in cycle t+1 and `ren` is never asserted.
- With `dout_ready` low, at most 2 words are buffered plus 0 in flight; `ren` stays low until a pop frees a slot.
- Outputs are combinational from `dout_ready` only via the `ren` issue condition.

## Configuration
- **`PHASE_VEC_READER_CHECKSUM_EN` defined:**
  - `checksum` is the running DATA_WIDTH-bit wrap-around sum of every accepted `dout` word.
  - Cleared when `start` is accepted.
  - Final value valid from the `done` cycle and held until the next accepted `start`.
- **Undefined:** the `checksum` port and its logic are absent; all other behaviour is identical.

## Structure
- **Shared package:** the state encoding (IDLE/READ/DRAIN/DONE, 2 bits) and the buffer depth constant (2).
- **Sub-module:** a 2-entry synchronous FIFO, `phase_vec_rd_buf`, with push/pop/`occ`, and clear on `rst`.
- **Top level:** FSM, address/length counters, issue logic, optional checksum.

## Test plan
- **Full-rate read:** SRAM preloaded with `mem[i]` = i, `base_adr` = 0, `len` = 4, `dout_ready` = 1 → `dout` 0,1,2,3 in cycles t+3..t+6, `done` in t+7; `checksum` = 6 when enabled.
- **Address wrap:** `base_adr` = 2046, `len` = 4 → `radr` 2046, 2047, 0, 1; `dout` matches `mem` in that order.
- **Back-pressure:** `len` = 8 with `dout_ready` toggling 1,0,0,1,… → all 8 words in order, no duplicates, `dout` stable while stalled, `ren` never issued with 2 buffered plus 1 in flight.
- **Zero length / ignored start:** `len` = 0 → `done` at t+1 with no `ren`. `start` pulsed mid-transfer → ignored; word count unchanged.
- **Clamp:** `len` = 4095 → exactly 2048 words read, `done` once.
- **Reset mid-operation:** assert `rst` at word 3 of 10 → next cycle all outputs 0, state IDLE. A following `start` with `len` = 2 yields exactly 2 words.
